// File: rtl/weight_mem_responder.sv
// weight_mem_responder
//   Memory-side responder for the weight-fetch request/valid interface.
//   Holds the on-chip weight store (single port, registered read). An
//   off-chip load port writes the store. On a request, the block reads one
//   NUM_ELEM-word record starting at addr*NUM_ELEM, one word per cycle. It
//   then presents the whole record with a one-cycle valid strobe.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   load_en_i         off-chip write strobe (wins over a fetch read)
//   load_addr_i       word address of the write
//   load_data_i       write data
//   weight_request_i  level request from the weight controller
//   weight_addr_i     record index, latched when the request is accepted
//   weight_data_o     record, element k at [k*DATA_W +: DATA_W]
//   weight_valid_o    one-cycle response strobe
//   addr_err_o        record out of range, qualified by weight_valid_o
//   busy_o            request in progress (FETCH, RESP, WAIT_LOW)
module weight_mem_responder #(
    parameter int DATA_W    = 16,
    parameter int NUM_ELEM  = 18,
    parameter int MEM_DEPTH = 4096,
    parameter int MEM_AW    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en_i,
    input  logic [MEM_AW-1:0]          load_addr_i,
    input  logic [DATA_W-1:0]          load_data_i,
    input  logic                       weight_request_i,
    input  logic [15:0]                weight_addr_i,
    output logic [DATA_W*NUM_ELEM-1:0] weight_data_o,
    output logic                       weight_valid_o,
    output logic                       addr_err_o,
    output logic                       busy_o
);

    localparam int IDX_W  = $clog2(NUM_ELEM + 1);
    localparam int BASE_W = 16 + $clog2(NUM_ELEM);

    typedef enum logic [1:0] {IDLE, FETCH, RESP, WAIT_LOW} state_t;

    state_t              state, state_nxt;
    logic [BASE_W-1:0]   base_r;
    logic [BASE_W-1:0]   base_calc;
    logic                err_r;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    cap_idx;
    logic                pend;
    logic                rd_en;
    logic [MEM_AW-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    assign base_calc = BASE_W'(weight_addr_i) * BASE_W'(NUM_ELEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        rd_en          = 1'b0;
        rd_addr        = MEM_AW'(base_r + BASE_W'(idx));
        weight_valid_o = 1'b0;
        addr_err_o     = 1'b0;
        busy_o         = (state != IDLE);
        case (state)
            IDLE: begin
                if (weight_request_i) state_nxt = FETCH;
            end
            FETCH: begin
                if (err_r) begin
                    state_nxt = RESP;
                end else begin
                    // A load cycle owns the single port; the read waits.
                    rd_en = !load_en_i && (idx < IDX_W'(NUM_ELEM));
                    if (pend && cap_idx == IDX_W'(NUM_ELEM - 1)) state_nxt = RESP;
                end
            end
            RESP: begin
                weight_valid_o = 1'b1;
                addr_err_o     = err_r;
                state_nxt      = weight_request_i ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                if (!weight_request_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r        <= '0;
            err_r         <= 1'b0;
            idx           <= '0;
            cap_idx       <= '0;
            pend          <= 1'b0;
            weight_data_o <= '0;
        end else begin
            if (state == IDLE && weight_request_i) begin
                base_r <= base_calc;
                err_r  <= (base_calc + BASE_W'(NUM_ELEM - 1)) >= BASE_W'(MEM_DEPTH);
                idx    <= '0;
            end
            if (state == FETCH && err_r) weight_data_o <= '0;
            // Read data lands one cycle after issue, even across a load stall,
            // because rd_data only changes on a read.
            pend <= rd_en;
            if (rd_en) begin
                idx     <= idx + IDX_W'(1);
                cap_idx <= idx;
            end
            for (int unsigned k = 0; k < NUM_ELEM; k++) begin
                if (pend && cap_idx == IDX_W'(k))
                    weight_data_o[k*DATA_W +: DATA_W] <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_en_i)  mem[load_addr_i] <= load_data_i;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_weight_mem_responder.sv
module tb_weight_mem_responder;

    localparam int DATA_W    = 16;
    localparam int NUM_ELEM  = 18;
    localparam int MEM_DEPTH = 4096;
    localparam int MEM_AW    = 12;
    localparam int REC_W     = DATA_W * NUM_ELEM;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_en_i = 1'b0;
    logic [MEM_AW-1:0] load_addr_i = '0;
    logic [DATA_W-1:0] load_data_i = '0;
    logic              weight_request_i = 1'b0;
    logic [15:0]       weight_addr_i = '0;
    logic [REC_W-1:0]  weight_data_o;
    logic              weight_valid_o;
    logic              addr_err_o;
    logic              busy_o;

    weight_mem_responder #(
        .DATA_W(DATA_W), .NUM_ELEM(NUM_ELEM), .MEM_DEPTH(MEM_DEPTH), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .reset(reset),
        .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
        .weight_request_i(weight_request_i), .weight_addr_i(weight_addr_i),
        .weight_data_o(weight_data_o), .weight_valid_o(weight_valid_o),
        .addr_err_o(addr_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [REC_W-1:0] data;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] tb_mem [0:63];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_valid  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [REC_W-1:0] build_rec(input int base);
        logic [REC_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_ELEM; k++) r[k*DATA_W +: DATA_W] = tb_mem[base + k];
        return r;
    endfunction

    task automatic push_exp(input logic [REC_W-1:0] d, input logic e, input int c);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = c;
        sb.push_back(x);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        @(negedge clk);
        load_en_i   = 1'b1;
        load_addr_i = MEM_AW'(a);
        load_data_i = d;
        tb_mem[a]   = d;
        @(negedge clk);
        load_en_i = 1'b0;
    endtask

    task automatic start_req(input logic [15:0] a, output int t);
        @(negedge clk);
        weight_request_i = 1'b1;
        weight_addr_i    = a;
        t                = cyc;
    endtask

    task automatic drop_req();
        @(negedge clk);
        weight_request_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard side: every valid must match the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && weight_valid_o) begin
            n_valid++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
                check("addr_err", 32'(addr_err_o), 32'(e.err));
                for (int k = 0; k < NUM_ELEM; k++)
                    check($sformatf("elem%0d", k), sext(weight_data_o[k*DATA_W +: DATA_W]),
                          sext(e.data[k*DATA_W +: DATA_W]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int t, t2, nv;
        logic [REC_W-1:0] x;

        for (int i = 0; i < 64; i++) tb_mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(weight_valid_o), 32'd0);
        check("rst_err", 32'(addr_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(|weight_data_o), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 36; k++) load_word(k, 16'(k + 1));

        // In-range fetch, request held high 5 cycles past valid
        start_req(16'd1, t);
        push_exp(build_rec(18), 1'b0, t + 20);
        nv = n_valid;
        wait_until(t + 1);
        check("busy_t1", 32'(busy_o), 32'd1);
        weight_addr_i = 16'hFFFF;
        wait_until(t + 25);
        check("single_valid", 32'(n_valid - nv), 32'd1);
        check("busy_wait_low", 32'(busy_o), 32'd1);
        weight_request_i = 1'b0;
        wait_until(t + 27);
        check("busy_idle", 32'(busy_o), 32'd0);
        wait_drain(5);

        // Three load stalls hitting a not-yet-read word
        start_req(16'd0, t);
        x = build_rec(0);
        x[17*DATA_W +: DATA_W] = 16'h7FFF;
        push_exp(x, 1'b0, t + 23);
        wait_until(t + 3);
        load_en_i = 1'b1; load_addr_i = 12'd17; load_data_i = 16'h1111;
        wait_until(t + 4);
        load_data_i = 16'h2222;
        wait_until(t + 5);
        load_data_i = 16'h7FFF;
        wait_until(t + 6);
        load_en_i = 1'b0;
        tb_mem[17] = 16'h7FFF;
        wait_drain(40);
        drop_req();

        // Write to an already-read word leaves the in-flight record intact
        start_req(16'd0, t);
        push_exp(build_rec(0), 1'b0, t + 21);
        wait_until(t + 10);
        load_en_i = 1'b1; load_addr_i = 12'd0; load_data_i = 16'h5555;
        wait_until(t + 11);
        load_en_i = 1'b0;
        tb_mem[0] = 16'h5555;
        wait_drain(40);
        drop_req();

        // Out of range: base 4104
        start_req(16'd228, t);
        push_exp('0, 1'b1, t + 2);
        wait_drain(10);
        drop_req();

        // Back-to-back: drop in RESP, re-request next cycle
        start_req(16'd0, t);
        push_exp(build_rec(0), 1'b0, t + 20);
        wait_until(t + 20);
        weight_request_i = 1'b0;
        wait_until(t + 21);
        check("b2b_no_wait_low", 32'(busy_o), 32'd0);
        weight_request_i = 1'b1;
        t2 = cyc;
        push_exp(build_rec(0), 1'b0, t2 + 20);
        wait_drain(60);
        drop_req();

        // Negative data
        for (int k = 0; k < NUM_ELEM; k++) load_word(k, 16'h8000);
        start_req(16'd0, t);
        push_exp(build_rec(0), 1'b0, t + 20);
        wait_drain(40);
        check("neg_elem0", sext(weight_data_o[DATA_W-1:0]), 32'hFFFF8000);
        check("neg_elem17", sext(weight_data_o[17*DATA_W +: DATA_W]), 32'hFFFF8000);
        drop_req();

        // Reset mid-fetch
        start_req(16'd1, t);
        nv = n_valid;
        wait_until(t + 10);
        reset = 1'b1;
        weight_request_i = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_valid", 32'(weight_valid_o), 32'd0);
        check("mid_rst_data", 32'(|weight_data_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("aborted_no_valid", 32'(n_valid - nv), 32'd0);
        start_req(16'd1, t);
        push_exp(build_rec(18), 1'b0, t + 20);
        wait_drain(40);
        drop_req();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
